// File: rtl/traffic_sensor_conditioner.sv
// Two-lane vehicle-detector conditioner: synchronizer, debounce, presence hold,
// stuck-sensor detection and saturating vehicle counts driving TA/TB.
module traffic_sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 8,
    parameter int unsigned STUCK_CYCLES    = 1000,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw_a,
    input  logic             raw_b,
    input  logic             cnt_clr,
    input  logic             flt_clr,
    output logic             TA,
    output logic             TB,
    output logic             fault_a,
    output logic             fault_b,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    localparam int unsigned DW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW    = $clog2(HOLD_CYCLES + 2);
    localparam int unsigned SW    = $clog2(STUCK_CYCLES + 1);
    localparam int unsigned HLOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESENT = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;
    localparam logic [1:0] FAULT   = 2'd3;

    logic [1:0] raw_in;
    assign raw_in = {raw_b, raw_a};

    for (genvar i = 0; i < 2; i++) begin : g_lane
        logic             sync1;
        logic             s;
        logic             f;
        logic [DW-1:0]    dcnt;
        logic             flip;
        logic             rise;
        logic             fall;
        logic [1:0]       state;
        logic [1:0]       state_nxt;
        logic [HW-1:0]    htmr;
        logic [HW-1:0]    htmr_nxt;
        logic [SW-1:0]    stmr;
        logic [SW-1:0]    stmr_nxt;
        logic             enter;
        logic             present_q;
        logic             fault_q;
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                sync1 <= 1'b0;
                s     <= 1'b0;
            end else begin
                sync1 <= raw_in[i];
                s     <= sync1;
            end
        end

        // The flip is exposed as rise/fall events so the FSM reacts on the
        // same edge that f changes, keeping TA aligned with f.
        assign flip = (s != f) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
        assign rise = flip & s;
        assign fall = flip & ~s;

        always_ff @(posedge clk) begin
            if (!rst) begin
                f    <= 1'b0;
                dcnt <= '0;
            end else if (s == f) begin
                dcnt <= '0;
            end else if (flip) begin
                f    <= s;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end

        always_comb begin
            state_nxt = state;
            htmr_nxt  = htmr;
            stmr_nxt  = stmr;
            enter     = 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_nxt = PRESENT;
                        enter     = 1'b1;
                    end
                end
                PRESENT: begin
                    if (fall) begin
                        if (HOLD_CYCLES == 0) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = HOLD;
                            htmr_nxt  = HW'(HLOAD);
                        end
                    end else if (f && (stmr == SW'(STUCK_CYCLES - 1))) begin
                        state_nxt = FAULT;
                    end else begin
                        stmr_nxt = stmr + 1'b1;
                    end
                end
                HOLD: begin
                    if (rise) begin
                        state_nxt = PRESENT;
                        enter     = 1'b1;
                    end else if (htmr == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        htmr_nxt = htmr - 1'b1;
                    end
                end
                FAULT: begin
                    if (flt_clr && !f) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (enter) begin
                stmr_nxt = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                state     <= IDLE;
                htmr      <= '0;
                stmr      <= '0;
                present_q <= 1'b0;
                fault_q   <= 1'b0;
                cnt_q     <= '0;
            end else begin
                state     <= state_nxt;
                htmr      <= htmr_nxt;
                stmr      <= stmr_nxt;
                present_q <= (state_nxt == PRESENT) || (state_nxt == HOLD);
                fault_q   <= (state_nxt == FAULT);
                if (cnt_clr) begin
                    cnt_q <= '0;
                end else if (enter && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign TA      = g_lane[0].present_q;
    assign TB      = g_lane[1].present_q;
    assign fault_a = g_lane[0].fault_q;
    assign fault_b = g_lane[1].fault_q;
    assign cnt_a   = g_lane[0].cnt_q;
    assign cnt_b   = g_lane[1].cnt_q;

endmodule
